// File: rtl/if_stage_if.sv
// Bundle of the fetch-stage control, instruction-memory and IF/ID signals.
// The master side is the fetch stage; the slave side is its environment.
interface if_stage_if;
  logic        start_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        flush_o;
  logic        done_o;

  modport master (
    input  start_i,
    input  stall_i,
    input  branch_taken_i,
    input  branch_target_i,
    input  imem_data_i,
    output imem_addr_o,
    output instr_o,
    output pc_o,
    output flush_o,
    output done_o
  );

  modport slave (
    output start_i,
    output stall_i,
    output branch_taken_i,
    output branch_target_i,
    output imem_data_i,
    input  imem_addr_o,
    input  instr_o,
    input  pc_o,
    input  flush_o,
    input  done_o
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC sequencing, branch squash,
// load-use hold and an end-of-program drain before signalling done.
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS   = 256,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input logic      clk_i,
  input logic      rst_i,
  if_stage_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [31:0] EndAddr   = 32'(IMEM_WORDS * 4);
  localparam logic [3:0]  DrainLoad = 4'(DRAIN_CYCLES - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_id_q;
  logic        flush_q;
  logic        done_q;
  logic [3:0]  drain_cnt_q;

  logic [31:0] target_d;
  logic [31:0] pc_inc_d;
  logic        at_end;
  logic        target_in_range;

  assign target_d        = bus.branch_target_i & ~32'h3;
  assign pc_inc_d        = pc_q + 32'd4;
  assign at_end          = (pc_q >= EndAddr);
  assign target_in_range = (target_d < EndAddr);

  assign bus.imem_addr_o = pc_q;
  assign bus.instr_o     = instr_q;
  assign bus.pc_o        = pc_id_q;
  assign bus.flush_o     = flush_q;
  assign bus.done_o      = done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc_id_q     <= 32'h0;
      flush_q     <= 1'b1;
      done_q      <= 1'b0;
      drain_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start_i) state_q <= StRun;
        end

        StRun: begin
          // A stalled branch sits in ID, so it is only honoured once the stall drops.
          if (!bus.stall_i) begin
            if (bus.branch_taken_i) begin
              pc_q    <= target_d;
              instr_q <= NOP_INSTR;
              pc_id_q <= pc_q;
              flush_q <= 1'b1;
            end else if (at_end) begin
              instr_q     <= NOP_INSTR;
              flush_q     <= 1'b1;
              drain_cnt_q <= DrainLoad;
              state_q     <= StDrain;
            end else begin
              instr_q <= bus.imem_data_i;
              pc_id_q <= pc_q;
              flush_q <= 1'b0;
              pc_q    <= pc_inc_d;
            end
          end
        end

        StDrain: begin
          instr_q <= NOP_INSTR;
          flush_q <= 1'b1;
          if (!bus.stall_i) begin
            // A late branch back into the program resumes fetching instead of finishing.
            if (bus.branch_taken_i && target_in_range) begin
              pc_q        <= target_d;
              state_q     <= StRun;
              drain_cnt_q <= 4'd0;
            end else if (drain_cnt_q == 4'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q - 4'd1;
            end
          end
        end

        StDone: begin
          done_q <= 1'b1;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage against a cycle-level behavioural model.
module tb_if_stage;
  localparam int unsigned IW    = 8;
  localparam int unsigned DC    = 4;
  localparam int unsigned END_A = IW * 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  if_stage_if bus ();

  if_stage #(
    .RESET_PC    (32'h0),
    .IMEM_WORDS  (IW),
    .DRAIN_CYCLES(DC),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [IW];
  assign bus.imem_data_i = (bus.imem_addr_o < END_A) ? mem[bus.imem_addr_o[4:2]] : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        done;
    logic        pc_known;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   started = 1'b0;

  // Model state
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcreg;
  logic        m_flush;
  logic        m_done;
  logic        m_pc_known;
  int          m_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase    = PH_IDLE;
    m_pc       = 32'h0;
    m_instr    = NOP;
    m_pcreg    = 32'h0;
    m_flush    = 1'b1;
    m_done     = 1'b0;
    m_pc_known = 1'b1;
    m_left     = 0;
  endfunction

  function automatic void model_step(input logic start, input logic stall, input logic br,
                                     input logic [31:0] tgt);
    logic [31:0] at;
    at = {tgt[31:2], 2'b00};
    case (m_phase)
      PH_IDLE: if (start) m_phase = PH_RUN;
      PH_RUN: begin
        if (stall) begin
        end else if (br) begin
          m_pcreg    = m_pc;
          m_pc_known = 1'b1;
          m_pc       = at;
          m_instr    = NOP;
          m_flush    = 1'b1;
        end else if (m_pc >= END_A) begin
          m_instr    = NOP;
          m_flush    = 1'b1;
          m_pc_known = 1'b0;
          m_left     = DC;
          m_phase    = PH_DRAIN;
        end else begin
          m_instr    = mem[m_pc / 4];
          m_pcreg    = m_pc;
          m_pc_known = 1'b1;
          m_flush    = 1'b0;
          m_pc       = m_pc + 4;
        end
      end
      PH_DRAIN: begin
        if (stall) begin
        end else if (br && at < END_A) begin
          m_pc    = at;
          m_phase = PH_RUN;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_phase = PH_DONE;
            m_done  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.addr     = m_pc;
    e.instr    = m_instr;
    e.pc       = m_pcreg;
    e.flush    = m_flush;
    e.done     = m_done;
    e.pc_known = m_pc_known;
    return e;
  endfunction

  task automatic check_now(input exp_t e);
    chk("imem_addr", bus.imem_addr_o, e.addr);
    chk("instr", bus.instr_o, e.instr);
    chk("flush", {31'h0, bus.flush_o}, {31'h0, e.flush});
    chk("done", {31'h0, bus.done_o}, {31'h0, e.done});
    if (e.pc_known) chk("pc", bus.pc_o, e.pc);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < int'(IW); i++) mem[i] = $urandom;
    check_now(snapshot());
  endtask

  // Monitor: one expected response is due shortly after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
        end else begin
          check_now(q.pop_front());
        end
      end
    end
  end

  initial begin
    int done_cycles;
    logic start, stall, br;
    logic [31:0] tgt;
    bus.start_i         = 1'b0;
    bus.stall_i         = 1'b0;
    bus.branch_taken_i  = 1'b0;
    bus.branch_target_i = 32'h0;
    done_cycles         = 0;
    pulse_reset();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (m_phase == PH_DONE) done_cycles++;
      else done_cycles = 0;
      if ($urandom_range(0, 199) == 0 || done_cycles >= 3) begin
        pulse_reset();
        done_cycles = 0;
      end
      start = (m_phase == PH_IDLE) ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 4) == 0);
      br    = ($urandom_range(0, 6) == 0);
      tgt   = $urandom_range(0, END_A + 15);
      bus.start_i         = start;
      bus.stall_i         = stall;
      bus.branch_taken_i  = br;
      bus.branch_target_i = tgt;
      model_step(start, stall, br, tgt);
      q.push_back(snapshot());
      started = 1'b1;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
